// File: rtl/exp_sub_pipe_pkg.sv
// Shared FPU exponent-path definitions for the exponent subtractor.
// Holds the default exponent/shift widths, the shift saturation value and
// the stage-1 payload carried between the two pipeline stages.
package exp_sub_pipe_pkg;

    localparam int EXP_W     = 13;
    localparam int SHAMT_W   = 7;
    localparam int SHAMT_MAX = 106;

    // The carry chain is cut after bit 6; the low half resolves in stage 1.
    localparam int LOW_W  = 7;
    localparam int HIGH_W = EXP_W - LOW_W;

    // Only the upper-half propagate/generate bits travel to stage 2; the low
    // half is already collapsed into lowsum and the group carry c7.
    typedef struct packed {
        logic [HIGH_W-1:0] p;
        logic [HIGH_W-1:0] g;
        logic [LOW_W-1:0]  lowsum;
        logic              c7;
    } s1_payload_t;

endpackage

// File: rtl/exp_sub_prefix.sv
// Combinational prefix-network exponent subtractor, split at the pipeline cut.
//   a, b     : minuend / subtrahend exponents (front half, feeds stage 1 regs)
//   s1_next  : stage-1 payload computed from a, b
//   s1_q     : registered stage-1 payload (back half, feeds stage 2 regs)
//   diff     : (a - b) mod 2**WIDTH
//   borrow   : a < b (unsigned)
//   absdiff  : |a - b|
//   shamt    : min(absdiff, SHMAX)
//   eq       : a == b
module exp_sub_prefix
    import exp_sub_pipe_pkg::*;
#(
    parameter int WIDTH = EXP_W,
    parameter int SHW   = SHAMT_W,
    parameter int SHMAX = SHAMT_MAX
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output s1_payload_t      s1_next,
    input  s1_payload_t      s1_q,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [WIDTH-1:0] absdiff,
    output logic [SHW-1:0]   shamt,
    output logic             eq
);

    localparam int HI = WIDTH - LOW_W;

    // Kogge-Stone tree. The carry-in is folded into bit 0's generate so that
    // each final group generate is the carry out of that bit. Updating from
    // the top down lets each black cell read its lower neighbour's value from
    // the previous level in place.
    function automatic logic [LOW_W:0] carry_lo(input logic [LOW_W-1:0] g_in,
                                                input logic [LOW_W-1:0] p_in,
                                                input logic             cin);
        logic [LOW_W-1:0] gg;
        logic [LOW_W-1:0] pp;
        gg    = g_in;
        pp    = p_in;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int d = 1; d < LOW_W; d = d * 2) begin
            for (int i = LOW_W - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        return {gg, cin};
    endfunction

    function automatic logic [HI:0] carry_hi(input logic [HI-1:0] g_in,
                                             input logic [HI-1:0] p_in,
                                             input logic          cin);
        logic [HI-1:0] gg;
        logic [HI-1:0] pp;
        gg    = g_in;
        pp    = p_in;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int d = 1; d < HI; d = d * 2) begin
            for (int i = HI - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        return {gg, cin};
    endfunction

    logic [WIDTH-1:0] p_full;
    logic [WIDTH-1:0] g_full;
    logic [LOW_W:0]   c_lo;
    logic [HI:0]      c_hi;

    // a - b = a + ~b + 1
    assign p_full = a ^ ~b;
    assign g_full = a & ~b;
    assign c_lo   = carry_lo(g_full[LOW_W-1:0], p_full[LOW_W-1:0], 1'b1);

    assign s1_next = '{
        p:      p_full[WIDTH-1:LOW_W],
        g:      g_full[WIDTH-1:LOW_W],
        lowsum: p_full[LOW_W-1:0] ^ c_lo[LOW_W-1:0],
        c7:     c_lo[LOW_W]
    };

    assign c_hi    = carry_hi(s1_q.g, s1_q.p, s1_q.c7);
    assign diff    = {s1_q.p ^ c_hi[HI-1:0], s1_q.lowsum};
    assign borrow  = ~c_hi[HI];
    // Negating diff costs a single incrementer rather than a second subtractor.
    assign absdiff = borrow ? (~diff + WIDTH'(1)) : diff;
    assign eq      = (diff == '0);
    assign shamt   = (absdiff > WIDTH'(SHMAX)) ? SHW'(SHMAX) : absdiff[SHW-1:0];

endmodule

// File: rtl/exp_sub_pipe.sv
// Two-stage pipelined exponent subtractor (exp_a - exp_b) for FMA/add alignment.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : squashes both stages on the next edge
//   in_valid/in_ready   : operand handshake (exp_a, exp_b)
//   out_valid/out_ready : result handshake
//   diff, borrow, absdiff, shamt, eq : registered results of stage 2
module exp_sub_pipe
    import exp_sub_pipe_pkg::*;
#(
    parameter int WIDTH = EXP_W,
    parameter int SHW   = SHAMT_W,
    parameter int SHMAX = SHAMT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] exp_a,
    input  logic [WIDTH-1:0] exp_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [WIDTH-1:0] absdiff,
    output logic [SHW-1:0]   shamt,
    output logic             eq
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    s1_payload_t      s1_d;
    s1_payload_t      s1_q;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_d;
    logic [WIDTH-1:0] absdiff_d;
    logic [SHW-1:0]   shamt_d;
    logic             eq_d;

    exp_sub_prefix #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .SHMAX (SHMAX)
    ) u_prefix (
        .a       (exp_a),
        .b       (exp_b),
        .s1_next (s1_d),
        .s1_q    (s1_q),
        .diff    (diff_d),
        .borrow  (borrow_d),
        .absdiff (absdiff_d),
        .shamt   (shamt_d),
        .eq      (eq_d)
    );

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (!flush && s1_adv && in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Bubbles advance s2_valid only; held result data stays put.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            absdiff  <= '0;
            shamt    <= '0;
            eq       <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff    <= diff_d;
                borrow  <= borrow_d;
                absdiff <= absdiff_d;
                shamt   <= shamt_d;
                eq      <= eq_d;
            end
        end
    end

endmodule

// File: doc/exp_sub_pipe.md
Name: exp_sub_pipe

Overview:
- Two-stage pipelined 13-bit exponent subtractor, the subtract-direction counterpart of the FPU exponent adder.
- Computes ExpA - ExpB for FMA/add alignment: signed difference, borrow/swap flag, absolute difference and saturated alignment shift amount.
- Sits between operand unpack and the alignment shifter, with valid/ready flow control on both sides and a flush.

Parameters:
- WIDTH, 13, exponent width in bits.
- SHW, 7, width of the shift-amount output.
- SHMAX, 106, saturation value for the shift amount (2*53 for double); must be < 2**SHW.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of both pipeline stages.
- in_valid  in  1  operands valid.
- in_ready  out  1  stage 1 can accept this cycle.
- exp_a  in  WIDTH  minuend exponent (unsigned biased).
- exp_b  in  WIDTH  subtrahend exponent.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  (exp_a - exp_b) mod 2**WIDTH.
- borrow  out  1  1 iff exp_a < exp_b (unsigned); doubles as the swap flag.
- absdiff  out  WIDTH  |exp_a - exp_b|.
- shamt  out  SHW  min(absdiff, SHMAX).
- eq  out  1  1 iff exp_a == exp_b.

Behaviour:
- Arithmetic: diff = exp_a + ~exp_b + 1 using a parallel-prefix carry network (generate/propagate, carry-in 1). borrow = NOT carry-out.
  - absdiff = borrow ? (exp_b - exp_a) : diff. Compute it as the two's complement of diff with no extra full adder in stage 2's critical path beyond one incrementer.
  - eq = (diff == 0).
- Stage 1 (S1) registers:
  - bitwise p = a ^ ~b and g = a & ~b;
  - low-half (bits [6:0]) sums;
  - group carry c7 out of bit 6.
- Stage 2 (S2) registers:
  - upper-half sums using c7;
  - borrow, absdiff, shamt, eq.
- All outputs are driven directly from S2 registers.
- Latency: exactly 2 cycles from an accepted input to out_valid when never stalled. Throughput is 1 per cycle.
- Handshake:
  - Input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | S2 advances.
  - in_ready = !s1_valid | S2 advances (combinational from out_ready; no skid buffer).
  - While out_valid=1 & out_ready=0, every output holds stable and in_ready=0 once S1 is also full.
- Flush:
  - Next cycle s1_valid=0 and s2_valid=0; data registers are not required to clear.
  - A flush in the same cycle as in_valid&in_ready drops that input.
  - Flush overrides out_ready.
- Reset (async, any time, including mid-stall): s1_valid=s2_valid=0, out_valid=0, diff=0, borrow=0, absdiff=0, shamt=0, eq=0. in_ready=1 during and after reset.
- Boundaries:
  - a=b gives diff=0, borrow=0, eq=1, shamt=0.
  - a=0, b=2**WIDTH-1 gives diff=1, borrow=1, absdiff=2**WIDTH-1, shamt=SHMAX.
  - absdiff==SHMAX gives shamt=SHMAX.
  - Data regs load only on a stage advance with valid data. Bubbles do not disturb held outputs.

Decomposition:
- Shared FPU package: WIDTH default, SHMAX default, and a struct/typedef for the S1 payload (p, g, lowsum, c7).
- One sub-module, exp_sub_prefix: combinational WIDTH-bit prefix subtract network, reusing the existing black/grey cell style. The pipeline module handles registers and handshake only.

Test Plan:
- Reset then exp_a=13'h03FF, exp_b=13'h03F0 with out_ready=1 -> out_valid at cycle +2; diff=0x00F, borrow=0, absdiff=15, shamt=15, eq=0.
- exp_a=0x0010, exp_b=0x0400 -> diff=0x1C10, borrow=1, absdiff=0x03F0, shamt=106 (saturated); and a=b=0x0800 -> diff=0, eq=1, shamt=0.
- Back-to-back 4 inputs with out_ready=1 -> 4 results on consecutive cycles in order, in_ready stays 1.
- Hold out_ready=0 after 2 accepts -> in_ready=0 on the next cycle, outputs stable for 5 cycles. Raise out_ready -> results drain in order, nothing lost or duplicated.
- Assert flush with both stages full and a new input presented -> next cycle out_valid=0, in_ready=1, the flushed input never appears.
- Assert reset asynchronously mid-stall (between clock edges) -> out_valid and all data outputs read 0 immediately. The first post-reset input appears after exactly 2 cycles.
